// File: rtl/dispensador_pkg.sv
// dispensador_pkg: state encoding and count width shared by the dispenser sequencer
package dispensador_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, FAULT} state_t;
endpackage

// File: rtl/temporizador.sv
// temporizador: loadable up-counter that flags when it reaches the given limit
module temporizador #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] lim,
  output logic         expired
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? '0 : count_q + 1'b1;
  always_ff @(posedge clk) count_q <= !reset_n ? '0 : count_d;
  assign expired = count_q == lim;
endmodule

// File: rtl/dispensador_control.sv
// dispensador_control: one dispense cycle sequencer, watchdog and FAULT state under DISPENSADOR_WATCHDOG_EN
module dispensador_control
  import dispensador_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SETTLE_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cantidad,
  input  logic             salida_apagado,
  output logic             cnt_reset,
  output logic [CNT_W-1:0] maximo,
  output logic             motor_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             fault
);
  localparam int MAX_C = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int W = $clog2(MAX_C + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] maximo_q, maximo_d;
  logic cnt_reset_q, cnt_reset_d, motor_en_q, motor_en_d, busy_q, busy_d;
  logic done_q, done_d, aborted_q, aborted_d, fault_q, fault_d;
  logic expired;
  temporizador #(.W(W)) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_d != state_q),
    .lim     (state_q == RUN ? W'(TIMEOUT_CYCLES - 1) : W'(SETTLE_CYCLES - 1)),
    .expired (expired)
  );
  always_comb begin
    state_d   = state_q;
    maximo_d  = maximo_q;
    aborted_d = aborted_q;
    fault_d   = fault_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE, FAULT: if (start) begin
        if (cantidad != '0) begin
          state_d   = CLEAR;
          maximo_d  = cantidad;
          aborted_d = 1'b0;
          fault_d   = 1'b0;
        end else if (state_q == IDLE) done_d = 1'b1;
      end
      CLEAR: state_d = RUN;
      RUN: if (salida_apagado) state_d = SETTLE;
      else if (abort) begin
        state_d   = SETTLE;
        aborted_d = 1'b1;
      end
`ifdef DISPENSADOR_WATCHDOG_EN
      else if (expired) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
`endif
      SETTLE: if (expired) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cnt_reset_d = state_d inside {IDLE, CLEAR, FAULT};
    motor_en_d  = state_d == RUN;
    busy_d      = state_d inside {CLEAR, RUN, SETTLE};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      maximo_q    <= '0;
      cnt_reset_q <= 1'b1;
      motor_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      maximo_q    <= maximo_d;
      cnt_reset_q <= cnt_reset_d;
      motor_en_q  <= motor_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      fault_q     <= fault_d;
    end
  end
  assign cnt_reset = cnt_reset_q;
  assign maximo    = maximo_q;
  assign motor_en  = motor_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_dispensador_control.sv
// tb_dispensador_control: directed bench for dispensador_control with a behavioural contador in the loop
module tb_dispensador_control;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, salida_apagado;
  logic [3:0] cantidad = '0, maximo, cnt = '0;
  logic cnt_reset, motor_en, busy, done, aborted, fault;
  logic pulse = 1'b0, force_apagado = 1'b0;
  int vectors = 0, miscompares = 0;
  dispensador_control #(.TIMEOUT_CYCLES(20), .SETTLE_CYCLES(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .cantidad       (cantidad),
    .salida_apagado (salida_apagado),
    .cnt_reset      (cnt_reset),
    .maximo         (maximo),
    .motor_en       (motor_en),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .fault          (fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt_reset ? 4'd0 : cnt + {3'd0, pulse};
  assign salida_apagado = force_apagado || (!cnt_reset && cnt >= maximo);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  task automatic req(input logic [3:0] q);
    cantidad = q;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    int n;
    step();
    step();
    chk("rst_cnt_reset", cnt_reset, 1);
    chk("rst_maximo", maximo, 0);
    chk("rst_motor", motor_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_fault", fault, 0);
    reset_n = 1'b1;
    step();
    req(4'd3);
    chk("n_clear_busy", busy, 1);
    chk("n_clear_cnt_reset", cnt_reset, 1);
    chk("n_maximo", maximo, 3);
    chk("n_clear_motor", motor_en, 0);
    step();
    chk("n_run_motor", motor_en, 1);
    chk("n_run_cnt_reset", cnt_reset, 0);
    pulse = 1'b1;
    repeat (3) step();
    pulse = 1'b0;
    chk("n_motor_before_m", motor_en, 1);
    step();
    chk("n_motor_off", motor_en, 0);
    chk("n_settle_busy", busy, 1);
    step();
    step();
    chk("n_done_early", done, 0);
    step();
    chk("n_done", done, 1);
    chk("n_busy_drop", busy, 0);
    chk("n_aborted", aborted, 0);
    chk("n_fault", fault, 0);
    step();
    chk("n_done_1cyc", done, 0);
    req(4'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_motor", motor_en, 0);
    step();
    chk("z_done_1cyc", done, 0);
    chk("z_motor2", motor_en, 0);
    req(4'd5);
    step();
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("a_motor_off", motor_en, 0);
    step();
    step();
    chk("a_done_early", done, 0);
    step();
    chk("a_done", done, 1);
    chk("a_aborted", aborted, 1);
    step();
    req(4'd5);
    chk("s_aborted_clr", aborted, 0);
    step();
    force_apagado = 1'b1;
    abort = 1'b1;
    step();
    force_apagado = 1'b0;
    abort = 1'b0;
    chk("s_motor_off", motor_en, 0);
    repeat (2) step();
    step();
    chk("s_done", done, 1);
    chk("s_aborted", aborted, 0);
    step();
    req(4'd7);
    step();
    req(4'd2);
    chk("r_start_ignored_max", maximo, 7);
    chk("r_start_ignored_motor", motor_en, 1);
    do_reset();
    chk("r_motor", motor_en, 0);
    chk("r_cnt_reset", cnt_reset, 1);
    chk("r_busy", busy, 0);
    chk("r_maximo", maximo, 0);
    step();
    chk("r_idle_motor", motor_en, 0);
    req(4'd5);
    step();
    n = 0;
`ifdef DISPENSADOR_WATCHDOG_EN
    while (motor_en && n < 40) begin
      n++;
      step();
    end
    chk("t_motor_cycles", n, 20);
    chk("t_fault", fault, 1);
    chk("t_busy", busy, 0);
    chk("t_cnt_reset", cnt_reset, 1);
    step();
    chk("t_fault_sticky", fault, 1);
    req(4'd2);
    chk("t_fault_clr", fault, 0);
    chk("t_retry_busy", busy, 1);
    step();
    chk("t_retry_motor", motor_en, 1);
`else
    repeat (100) begin
      step();
      if (motor_en) n++;
    end
    chk("nw_motor_cycles", n, 100);
    chk("nw_motor", motor_en, 1);
    chk("nw_fault", fault, 0);
`endif
    do_reset();
    chk("end_motor", motor_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
